// File: rtl/grid_pkg.sv
// Shared constants, colours and FSM state encoding for the grid redraw controller.
package grid_pkg;

  localparam int GRID_SIZE     = 28;
  localparam int PIXEL_SIZE    = 4;
  localparam int GRID_OFFSET_X = 16;
  localparam int GRID_OFFSET_Y = 12;
  localparam int PIX_BITS      = $clog2(PIXEL_SIZE);
  localparam int GRID_SPAN     = GRID_SIZE * PIXEL_SIZE;

  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_BLUE  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PAINT  = 3'd3,
    ST_BORDER = 3'd4,
    ST_FIN    = 3'd5
  } grid_state_e;

  // The cursor cell is drawn in blue/red so it stays visible on either cell value.
  function automatic logic [2:0] cell_colour(input logic cell_bit, input logic hit);
    if (hit) return cell_bit ? COL_BLUE : COL_RED;
    return cell_bit ? COL_BLACK : COL_WHITE;
  endfunction

endpackage

// File: rtl/grid_cell_painter.sv
// Expands one grid cell into PIXEL_SIZE x PIXEL_SIZE plot writes (dx inner, dy outer).
module grid_cell_painter
  import grid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] cx,
  input  logic [4:0] cy,
  input  logic       cell_bit,
  input  logic       hit,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       last
);

  logic                r_active;
  logic [PIX_BITS-1:0] r_dx;
  logic [PIX_BITS-1:0] r_dy;
  logic [4:0]          r_cx;
  logic [4:0]          r_cy;
  logic [2:0]          r_colour;
  logic                w_dx_max;
  logic                w_dy_max;

  assign w_dx_max = (r_dx == PIX_BITS'(PIXEL_SIZE - 1));
  assign w_dy_max = (r_dy == PIX_BITS'(PIXEL_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_colour <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_dx     <= '0;
      r_dy     <= '0;
      r_cx     <= cx;
      r_cy     <= cy;
      r_colour <= cell_colour(cell_bit, hit);
    end else if (r_active) begin
      if (w_dx_max) begin
        r_dx <= '0;
        if (w_dy_max) r_active <= 1'b0;
        else          r_dy <= r_dy + 1'b1;
      end else begin
        r_dx <= r_dx + 1'b1;
      end
    end
  end

  assign plot   = r_active;
  assign x      = 8'(GRID_OFFSET_X + int'(r_cx) * PIXEL_SIZE + int'(r_dx));
  assign y      = 7'(GRID_OFFSET_Y + int'(r_cy) * PIXEL_SIZE + int'(r_dy));
  assign colour = r_colour;
  assign last   = r_active && w_dx_max && w_dy_max;

endmodule

// File: rtl/grid_redraw_ctrl.sv
// Sequences full-grid and single-cell redraws into the vga_adapter frame buffer.
// Optional GRID_BORDER_EN adds a black 1-pixel frame after each full redraw.
module grid_redraw_ctrl
  import grid_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       full_req,
  input  logic       cell_valid,
  output logic       cell_ready,
  input  logic [4:0] cell_x,
  input  logic [4:0] cell_y,
  input  logic [4:0] cursor_x,
  input  logic [4:0] cursor_y,
  output logic       mem_rd_en,
  output logic [9:0] mem_addr,
  input  logic       mem_rdata,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  grid_state_e r_state, w_next;
  logic       r_full_pend, r_cell_pend, r_is_full;
  logic [4:0] r_px, r_py, r_cx, r_cy, r_curx, r_cury;
  logic       w_accept, w_disp_full, w_disp_cell, w_drop;
  logic       w_last_cell, w_hit, w_cell_in_range;
  logic       w_p_plot, w_p_last;
  logic [7:0] w_p_x;
  logic [6:0] w_p_y;
  logic [2:0] w_p_colour;

  // Cell handshake: a request transfers on any cycle where cell_valid && cell_ready.
  assign cell_ready      = !r_cell_pend;
  assign w_accept        = cell_valid && !r_cell_pend;
  assign w_last_cell     = (r_cx == 5'(GRID_SIZE - 1)) && (r_cy == 5'(GRID_SIZE - 1));
  assign w_hit           = (r_cx == r_curx) && (r_cy == r_cury);
  assign w_cell_in_range = (r_px < 5'(GRID_SIZE)) && (r_py < 5'(GRID_SIZE));

  grid_cell_painter u_painter (
    .clk      (CLOCK_50),
    .rst      (reset),
    .start    (r_state == ST_WAIT),
    .cx       (r_cx),
    .cy       (r_cy),
    .cell_bit (mem_rdata),
    .hit      (w_hit),
    .plot     (w_p_plot),
    .x        (w_p_x),
    .y        (w_p_y),
    .colour   (w_p_colour),
    .last     (w_p_last)
  );

`ifdef GRID_BORDER_EN
  logic [1:0] r_bside;
  logic [6:0] r_bcnt;
  logic [6:0] w_side_last;
  logic       w_border_last;
  logic [7:0] w_bx;
  logic [6:0] w_by;

  assign w_side_last   = (r_bside[1] == 1'b0) ? 7'(GRID_SPAN + 1) : 7'(GRID_SPAN - 1);
  assign w_border_last = (r_bside == 2'd3) && (r_bcnt == w_side_last);

  // Sides in order top, bottom, left, right; left/right skip the corner rows.
  always_comb begin
    w_bx = 8'(GRID_OFFSET_X - 1 + int'(r_bcnt));
    w_by = 7'(GRID_OFFSET_Y - 1);
    case (r_bside)
      2'd0: ;
      2'd1: w_by = 7'(GRID_OFFSET_Y + GRID_SPAN);
      2'd2: begin
        w_bx = 8'(GRID_OFFSET_X - 1);
        w_by = 7'(GRID_OFFSET_Y + int'(r_bcnt));
      end
      default: begin
        w_bx = 8'(GRID_OFFSET_X + GRID_SPAN);
        w_by = 7'(GRID_OFFSET_Y + int'(r_bcnt));
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || r_state != ST_BORDER) begin
      r_bside <= '0;
      r_bcnt  <= '0;
    end else if (r_bcnt == w_side_last) begin
      r_bside <= r_bside + 1'b1;
      r_bcnt  <= '0;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end
`endif

  always_comb begin
    w_next      = r_state;
    w_disp_full = 1'b0;
    w_disp_cell = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full_pend) begin
          w_disp_full = 1'b1;
          w_next      = ST_FETCH;
        end else if (r_cell_pend) begin
          if (w_cell_in_range) begin
            w_disp_cell = 1'b1;
            w_next      = ST_FETCH;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      ST_FETCH: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_PAINT;
      ST_PAINT: begin
        if (w_p_last) begin
          if (r_is_full && !w_last_cell) w_next = ST_FETCH;
`ifdef GRID_BORDER_EN
          else if (r_is_full)            w_next = ST_BORDER;
`endif
          else                           w_next = ST_FIN;
        end
      end
`ifdef GRID_BORDER_EN
      ST_BORDER: if (w_border_last) w_next = ST_FIN;
`endif
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_full_pend <= 1'b0;
      r_cell_pend <= 1'b0;
      r_is_full   <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_curx      <= '0;
      r_cury      <= '0;
    end else begin
      r_state <= w_next;
      if (full_req)         r_full_pend <= 1'b1;
      else if (w_disp_full) r_full_pend <= 1'b0;
      // A full redraw supersedes any buffered cell, even one accepted this cycle.
      if (w_disp_full)                r_cell_pend <= 1'b0;
      else if (w_accept)              r_cell_pend <= 1'b1;
      else if (w_disp_cell || w_drop) r_cell_pend <= 1'b0;
      if (w_accept) begin
        r_px <= cell_x;
        r_py <= cell_y;
      end
      if (w_disp_full || w_disp_cell) begin
        r_is_full <= w_disp_full;
        r_cx      <= w_disp_full ? 5'd0 : r_px;
        r_cy      <= w_disp_full ? 5'd0 : r_py;
        r_curx    <= cursor_x;
        r_cury    <= cursor_y;
      end else if (r_state == ST_PAINT && w_p_last && r_is_full && !w_last_cell) begin
        if (r_cx == 5'(GRID_SIZE - 1)) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
    done       = (r_state == ST_FIN);
    mem_rd_en  = (r_state == ST_FETCH);
    mem_addr   = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (r_state == ST_FETCH) mem_addr = 10'(int'(r_cy) * GRID_SIZE + int'(r_cx));
    if (r_state == ST_PAINT) begin
      vga_x      = w_p_x;
      vga_y      = w_p_y;
      vga_colour = w_p_colour;
      vga_plot   = w_p_plot;
    end
`ifdef GRID_BORDER_EN
    if (r_state == ST_BORDER) begin
      vga_x      = w_bx;
      vga_y      = w_by;
      vga_colour = COL_BLACK;
      vga_plot   = 1'b1;
    end
`endif
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_grid_redraw_ctrl.sv
// Self-checking bench for grid_redraw_ctrl: plot scoreboard, done latency and request ordering.
module tb_grid_redraw_ctrl;

  localparam int GS = 28;
  localparam int PS = 4;
  localparam int OX = 16;
  localparam int OY = 12;
`ifdef GRID_BORDER_EN
  localparam int FULL_LAT   = 14112 + 452;
  localparam int FULL_PLOTS = 12544 + 452;
`else
  localparam int FULL_LAT   = 14112;
  localparam int FULL_PLOTS = 12544;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset, full_req, cell_valid, cell_ready;
  logic [4:0] cell_x, cell_y, cursor_x, cursor_y;
  logic       mem_rd_en, mem_rdata;
  logic [9:0] mem_addr;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour, dbg_state;
  logic       vga_plot, busy, done;

  logic        mem_bits [0:GS*GS-1];
  logic [17:0] exp_q[$];
  logic [17:0] mon_w;
  logic        busy_q = 1'b0;
  int n_tests = 0, n_fail = 0;
  int plot_cnt = 0, done_cnt = 0, cyc = 0, t_start = 0, last_lat = 0;

  grid_redraw_ctrl dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .full_req   (full_req),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / memory model
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50)
    mem_rdata <= (mem_rd_en && mem_addr < 10'(GS*GS)) ? mem_bits[mem_addr] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLOCK_50) begin
    cyc++;
    if (vga_plot === 1'b1) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_plot_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_w = exp_q.pop_front();
        check("plot_xyc", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, mon_w});
      end
    end
    if (busy === 1'b1 && !busy_q) t_start = cyc;
    if (done === 1'b1) begin
      done_cnt++;
      last_lat = cyc - t_start;
    end
    busy_q = (busy === 1'b1);
  end

  function automatic logic [17:0] pw(input int x, input int y, input logic [2:0] c);
    return {8'(x), 7'(y), c};
  endfunction

  task automatic push_cell(input int cx, input int cy);
    logic b, hit;
    logic [2:0] c;
    b   = mem_bits[cy*GS + cx];
    hit = (cx == int'(cursor_x)) && (cy == int'(cursor_y));
    c   = hit ? (b ? 3'b001 : 3'b100) : (b ? 3'b000 : 3'b111);
    for (int dy = 0; dy < PS; dy++)
      for (int dx = 0; dx < PS; dx++)
        exp_q.push_back(pw(OX + cx*PS + dx, OY + cy*PS + dy, c));
  endtask

  task automatic push_full();
    for (int cy = 0; cy < GS; cy++)
      for (int cx = 0; cx < GS; cx++)
        push_cell(cx, cy);
`ifdef GRID_BORDER_EN
    for (int x = OX-1; x <= OX+GS*PS; x++) exp_q.push_back(pw(x, OY-1, 3'b000));
    for (int x = OX-1; x <= OX+GS*PS; x++) exp_q.push_back(pw(x, OY+GS*PS, 3'b000));
    for (int y = OY; y < OY+GS*PS; y++) exp_q.push_back(pw(OX-1, y, 3'b000));
    for (int y = OY; y < OY+GS*PS; y++) exp_q.push_back(pw(OX+GS*PS, y, 3'b000));
`endif
  endtask

  // driver tasks
  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic send_cell(input int x, input int y);
    int k = 0;
    while (cell_ready !== 1'b1 && k < 30000) begin
      step();
      k++;
    end
    check("send_ready_timeout", 32'(cell_ready), 32'd1);
    cell_valid = 1'b1;
    cell_x     = 5'(x);
    cell_y     = 5'(y);
    step();
    cell_valid = 1'b0;
  endtask

  task automatic pulse_full();
    full_req = 1'b1;
    step();
    full_req = 1'b0;
  endtask

  initial begin
    int base, p0, k, ax, ay, bx, by;
    reset = 1'b1; full_req = 1'b1; cell_valid = 1'b0;
    cell_x = '0; cell_y = '0; cursor_x = '0; cursor_y = '0;
    for (int i = 0; i < GS*GS; i++) mem_bits[i] = 1'b0;

    // reset with full_req held high
    run(3);
    check("rst_plot", 32'(vga_plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_x", 32'(vga_x), 0);
    check("rst_y", 32'(vga_y), 0);
    check("rst_colour", 32'(vga_colour), 0);
    check("rst_cell_ready", 32'(cell_ready), 1);
    reset = 1'b0; full_req = 1'b0;
    run(40);
    check("no_plot_after_reset", 32'(plot_cnt), 0);
    check("idle_after_reset", 32'(busy), 0);

    // full redraw, memory clear, cursor (14,14)
    cursor_x = 5'd14; cursor_y = 5'd14;
    base = done_cnt; p0 = plot_cnt;
    push_full();
    pulse_full();
    wait_done(base + 1, 16000, "full_done");
    check("full_latency", 32'(last_lat), 32'(FULL_LAT));
    check("full_plots", 32'(plot_cnt - p0), 32'(FULL_PLOTS));
    step();
    check("done_one_cycle", 32'(done), 0);

    // single cell (0,0) bit set, cursor elsewhere
    mem_bits[0] = 1'b1; cursor_x = 5'd5; cursor_y = 5'd5;
    base = done_cnt; p0 = plot_cnt;
    push_cell(0, 0);
    send_cell(0, 0);
    wait_done(base + 1, 100, "cell_done");
    check("cell_latency", 32'(last_lat), 18);
    check("cell_plots", 32'(plot_cnt - p0), 16);
    run(5);

    // two cells queued during a full op, random memory and cursor
    for (int i = 0; i < GS*GS; i++) mem_bits[i] = 1'($urandom_range(0, 1));
    cursor_x = 5'($urandom_range(0, GS-1)); cursor_y = 5'($urandom_range(0, GS-1));
    ax = $urandom_range(0, GS-1); ay = $urandom_range(0, GS-1);
    bx = $urandom_range(0, GS-1); by = $urandom_range(0, GS-1);
    base = done_cnt;
    push_full(); push_cell(ax, ay); push_cell(bx, by);
    pulse_full();
    k = 0;
    while (busy !== 1'b1 && k < 10) begin step(); k++; end
    check("full_started", 32'(busy), 1);
    send_cell(ax, ay);
    check("ready_low_after_a", 32'(cell_ready), 0);
    k = 0;
    while (cell_ready !== 1'b1 && k < 20000) begin step(); k++; end
    check("ready_held_until_full_end", 32'(done_cnt - base), 1);
    send_cell(bx, by);
    wait_done(base + 3, 200, "queued_cells_done");
    run(5);

    // full_req during a cell op with another cell pending
    ax = $urandom_range(0, GS-1); ay = $urandom_range(0, GS-1);
    base = done_cnt;
    push_cell(ax, ay); push_full();
    send_cell(ax, ay);
    send_cell((ax + 1) % GS, ay);
    check("pending_cell_buffered", 32'(cell_ready), 0);
    pulse_full();
    wait_done(base + 2, 16000, "cell_then_full_done");
    run(40);
    check("pending_cell_discarded", 32'(done_cnt - base), 2);
    check("ready_after_discard", 32'(cell_ready), 1);

    // out-of-range cells are dropped silently
    base = done_cnt; p0 = plot_cnt;
    send_cell(28, 3);
    run(10);
    send_cell(3, 31);
    run(30);
    check("oor_no_done", 32'(done_cnt - base), 0);
    check("oor_no_plots", 32'(plot_cnt - p0), 0);
    check("oor_ready", 32'(cell_ready), 1);

    // reset at plot 5 of a cell
    base = done_cnt; p0 = plot_cnt;
    push_cell(3, 4);
    send_cell(3, 4);
    k = 0;
    while (plot_cnt < p0 + 5 && k < 40) begin step(); k++; end
    check("reached_plot5", 32'(plot_cnt - p0), 5);
    reset = 1'b1;
    step();
    check("abort_plot", 32'(vga_plot), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(cell_ready), 1);
    reset = 1'b0;
    check("abort_queue_left", 32'(exp_q.size()), 11);
    exp_q.delete();
    run(30);
    check("abort_no_done", 32'(done_cnt - base), 0);
    check("abort_no_more_plots", 32'(plot_cnt - p0), 5);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
